// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS controller: state encodings, opcode/funct
// values, ALU control codes and datapath mux select codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ERROR     = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory ready handshake.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mctrl_alu_decode.sv
// R-type funct field to ALU control decoder; flags unsupported funct codes.
module mctrl_alu_decode
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control,
  output logic       o_funct_valid
);

  always_comb begin
    o_alu_control = ALU_AND;
    o_funct_valid = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_control = ALU_ADD;
      FN_SUB:  o_alu_control = ALU_SUB;
      FN_AND:  o_alu_control = ALU_AND;
      FN_OR:   o_alu_control = ALU_OR;
      FN_SLT:  o_alu_control = ALU_SLT;
      default: o_funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencer with memory-ready stretching, timeout to ERROR and
// optional performance counters (enabled by defining MCTRL_PERF_EN).
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_illegal;
  logic              w_timeout;
  logic [3:0]        w_alu_ctrl;
  logic              w_funct_valid;
  logic              w_pc_write;
  logic              w_ir_write;
  logic              w_reg_write;
  logic              w_mem_wen;

  mctrl_alu_decode u_alu_decode (
    .i_funct       (funct),
    .o_alu_control (w_alu_ctrl),
    .o_funct_valid (w_funct_valid)
  );

  assign w_timeout = (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_next = S_DECODE;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_ERROR;
        endcase
      end
      S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)      w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)      w_next = S_FETCH;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_EXECUTE:   w_next = w_funct_valid ? S_ALU_WB : S_ERROR;
      S_ALU_WB:    w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_ERROR:     w_next = S_ERROR;
      default:     w_next = S_ERROR;
    endcase
  end

  always_comb begin
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_wen   = 1'b0;
    iord        = 1'b0;
    mem_ren     = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    alu_control = ALU_AND;
    pc_source   = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        mem_ren     = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        w_ir_write  = mem_ready;
        w_pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = SRCB_IMM_SH;
        alu_control = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_ren = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEM_WRITE: begin
        w_mem_wen = 1'b1;
        iord      = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a   = 1'b1;
        alu_control = w_alu_ctrl;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_source   = PCSRC_ALUOUT;
        w_pc_write  = zero;
      end
      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Architectural write strobes are masked by reset so an async reset
  // mid-instruction cannot leak a partial write.
  assign pc_write  = w_pc_write  & reset;
  assign ir_write  = w_ir_write  & reset;
  assign reg_write = w_reg_write & reset;
  assign mem_wen   = w_mem_wen   & reset;
  assign state     = r_state;
  assign illegal   = r_illegal;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                      r_wait_cnt <= '0;
    else if (w_next != r_state)                      r_wait_cnt <= '0;
    else if (is_mem_state(r_state) && !mem_ready)    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  r_illegal <= 1'b0;
    else if (w_next == S_ERROR)  r_illegal <= 1'b1;
  end

`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instr_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (r_state != S_ERROR && r_cycle_cnt != '1)
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_next == S_FETCH && r_state != S_FETCH && r_instr_cnt != '1)
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign cycle_count = r_cycle_cnt;
  assign instr_count = r_instr_cnt;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and randomized instruction
// streams checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int TO = 15;

  localparam int P_FETCH = 0, P_DEC = 1, P_MADDR = 2, P_MRD = 3, P_MWB = 4,
                 P_MWR = 5, P_EXE = 6, P_AWB = 7, P_BR = 8, P_J = 9, P_ERR = 10;

`ifdef MCTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_ren;
    logic       mem_wen;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic [1:0] pc_source;
  } ctl_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, iord, mem_ren, mem_wen, ir_write, reg_dst, mem_to_reg, reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_control, state;
  logic        illegal;
  logic [31:0] cycle_count, instr_count;
  ctl_t        w_obs;

  int n_cmp = 0;
  int n_err = 0;
  int m_cycles = 0;
  int m_instr = 0;

  always #5 clock = ~clock;

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_source(pc_source), .state(state), .illegal(illegal),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  assign w_obs = {pc_write, iord, mem_ren, mem_wen, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_control, pc_source};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit fn_ok(input logic [5:0] fn);
    return fn inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'd32:   return 4'b0010;
      6'd34:   return 4'b0110;
      6'd36:   return 4'b0000;
      6'd37:   return 4'b0001;
      6'd42:   return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  // Control word each phase of an instruction must present.
  function automatic ctl_t exp_ctl(input int ph, input logic rdy, input logic z, input logic [5:0] fn);
    ctl_t c = '0;
    case (ph)
      P_FETCH: begin c.mem_ren = 1; c.alu_src_b = 2'b01; c.alu_control = 4'b0010;
                     c.ir_write = rdy; c.pc_write = rdy; end
      P_DEC:   begin c.alu_src_b = 2'b11; c.alu_control = 4'b0010; end
      P_MADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 4'b0010; end
      P_MRD:   begin c.mem_ren = 1; c.iord = 1; end
      P_MWB:   begin c.reg_write = 1; c.mem_to_reg = 1; end
      P_MWR:   begin c.mem_wen = 1; c.iord = 1; end
      P_EXE:   begin c.alu_src_a = 1; c.alu_control = alu_of(fn); end
      P_AWB:   begin c.reg_write = 1; c.reg_dst = 1; end
      P_BR:    begin c.alu_src_a = 1; c.alu_control = 4'b0110; c.pc_source = 2'b01;
                     c.pc_write = z; end
      P_J:     begin c.pc_source = 2'b10; c.pc_write = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk_counters();
    chk("cycle_count", 64'(cycle_count), PERF ? 64'(m_cycles) : 64'd0);
    chk("instr_count", 64'(instr_count), PERF ? 64'(m_instr) : 64'd0);
  endtask

  // One clock cycle in phase ph; entered just after a falling edge.
  task automatic cyc(input int ph, input logic rdy, input logic z, input bit retire);
    mem_ready = rdy;
    zero = z;
    #1;
    chk("ctl", {47'd0, w_obs}, {47'd0, exp_ctl(ph, rdy, z, funct)});
    if (ph <= P_MWB) chk("state", 64'(state), 64'(ph));
    chk("illegal", 64'(illegal), (ph == P_ERR) ? 64'd1 : 64'd0);
    chk("ren_wen_excl", 64'(mem_ren & mem_wen), 64'd0);
    chk_counters();
    @(negedge clock);
    if (ph != P_ERR) m_cycles++;
    if (retire) m_instr++;
  endtask

  task automatic do_reset();
    ctl_t e;
    reset = 1'b0;
    mem_ready = 1'b1;
    zero = rbit();
    #1;
    e = exp_ctl(P_FETCH, 1'b1, zero, funct);
    e.pc_write = 0;
    e.ir_write = 0;
    chk("reset_ctl", {47'd0, w_obs}, {47'd0, e});
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_illegal", 64'(illegal), 64'd0);
    m_cycles = 0;
    m_instr = 0;
    chk_counters();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic err_tail();
    for (int i = 0; i < 3; i++) cyc(P_ERR, rbit(), rbit(), 1'b0);
    do_reset();
  endtask

  task automatic mid_reset();
    mem_ready = 1'b1;
    #1;
    chk("wb_state", 64'(state), 64'd4);
    chk("wb_reg_write", 64'(reg_write), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_reg_write", 64'(reg_write), 64'd0);
    chk("abort_pc_ir", 64'({pc_write, ir_write}), 64'd0);
    chk("abort_state", 64'(state), 64'd0);
    @(negedge clock);
    m_cycles = 0;
    m_instr = 0;
    reset = 1'b1;
  endtask

  // Runs one instruction with fw / mw ready-low cycles in the fetch / data memory phase.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input int fw, input int mw, input bit abort_wb);
    int lows;
    opcode = 6'($urandom);
    funct = 6'($urandom);
    lows = (fw > TO) ? TO + 1 : fw;
    for (int i = 0; i < lows; i++) cyc(P_FETCH, 1'b0, rbit(), 1'b0);
    if (fw > TO) begin err_tail(); return; end
    cyc(P_FETCH, 1'b1, rbit(), 1'b0);
    opcode = op;
    funct = fn;
    cyc(P_DEC, rbit(), rbit(), 1'b0);
    case (op)
      6'd35, 6'd43: begin
        cyc(P_MADDR, rbit(), rbit(), 1'b0);
        lows = (mw > TO) ? TO + 1 : mw;
        for (int i = 0; i < lows; i++) cyc((op == 6'd35) ? P_MRD : P_MWR, 1'b0, rbit(), 1'b0);
        if (mw > TO) begin err_tail(); return; end
        if (op == 6'd43) cyc(P_MWR, 1'b1, rbit(), 1'b1);
        else begin
          cyc(P_MRD, 1'b1, rbit(), 1'b0);
          if (abort_wb) mid_reset();
          else cyc(P_MWB, rbit(), rbit(), 1'b1);
        end
      end
      6'd0: begin
        cyc(P_EXE, rbit(), rbit(), 1'b0);
        if (fn_ok(fn)) cyc(P_AWB, rbit(), rbit(), 1'b1);
        else err_tail();
      end
      6'd4: cyc(P_BR, rbit(), z, 1'b1);
      6'd2: cyc(P_J, rbit(), rbit(), 1'b1);
      default: err_tail();
    endcase
  endtask

  initial begin
    logic [5:0] ops [5];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    int fw, mw;
    ops = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd2};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

    @(negedge clock);
    do_reset();

    run(6'd35, 6'd0,  1'b0, 0, 0, 1'b0);   // lw
    run(6'd0,  6'd32, 1'b0, 0, 0, 1'b0);   // add
    run(6'd0,  6'd42, 1'b0, 1, 0, 1'b0);   // slt
    run(6'd4,  6'd0,  1'b1, 0, 0, 1'b0);   // beq taken
    run(6'd4,  6'd0,  1'b0, 0, 0, 1'b0);   // beq not taken
    run(6'd43, 6'd0,  1'b0, 0, 3, 1'b0);   // sw with 3 wait cycles
    run(6'd2,  6'd0,  1'b0, 2, 0, 1'b0);   // j
    run(6'd35, 6'd0,  1'b0, TO, TO, 1'b0); // longest legal waits
    run(6'd0,  6'd32, 1'b0, TO + 1, 0, 1'b0); // fetch timeout
    run(6'd8,  6'd32, 1'b0, 0, 0, 1'b0);   // illegal opcode
    run(6'd0,  6'd0,  1'b0, 0, 0, 1'b0);   // illegal funct
    run(6'd35, 6'd0,  1'b0, 0, 0, 1'b1);   // reset during MEM_WB
    run(6'd35, 6'd0,  1'b0, 0, TO + 1, 1'b0); // read timeout
    run(6'd43, 6'd0,  1'b0, 0, TO + 5, 1'b0); // write timeout

    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) fn = 6'($urandom);
      fw = ($urandom_range(0, 19) == 0) ? TO + 1 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 19) == 0) ? TO + 1 : int'($urandom_range(0, 3));
      run(op, fn, rbit(), fw, mw, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
